// File: rtl/ppu_oam_port_pkg.sv
// ppu_oam_port_pkg
// Shared PPU definitions used by the OAM register port and its sprite RAM.
// Contents:
//   PPU_REG_OAMADDR / PPU_REG_OAMDATA : register indices in the PPU slave window
//   OAM_ATTR_MASK                     : bits kept when storing a sprite attribute byte
//   OAM_DEPTH / OAM_AW                : sprite RAM depth and address width
//   oamStoreByte()                    : applies attribute masking to a byte being stored
package ppu_oam_port_pkg;

    localparam logic [2:0] PPU_REG_OAMADDR = 3'd3;
    localparam logic [2:0] PPU_REG_OAMDATA = 3'd4;

    localparam logic [7:0] OAM_ATTR_MASK = 8'hE3;

    localparam int OAM_DEPTH = 256;
    localparam int OAM_AW    = $clog2(OAM_DEPTH);

    // Byte 2 of every 4-byte sprite entry is the attribute byte; its bits 4:2
    // do not exist in hardware, so they are cleared before storage.
    function automatic logic [7:0] oamStoreByte(input logic       maskEn,
                                                input logic [7:0] addr,
                                                input logic [7:0] data);
        logic [7:0] result;
        result = data;
        if (maskEn && (addr[1:0] == 2'd2)) begin
            result = data & OAM_ATTR_MASK;
        end
        return result;
    endfunction

endpackage

// File: rtl/ppu_oam_port_oam_dpram.sv
// oam_dpram
// 256x8 synchronous dual-port sprite RAM, read-first on both ports.
// Ports:
//   clk_i      : clock
//   a_we_i     : port A write enable
//   a_addr_i   : port A write/read address
//   a_din_i    : port A write data
//   a_dout_o   : port A read data (1 clk latency, old data on same-address write)
//   b_en_i     : port B read enable (output holds when low)
//   b_addr_i   : port B read address
//   b_dout_o   : port B read data (1 clk latency, old data on same-address write)
module oam_dpram
    import ppu_oam_port_pkg::*;
(
    input  logic              clk_i,
    input  logic              a_we_i,
    input  logic [OAM_AW-1:0] a_addr_i,
    input  logic [7:0]        a_din_i,
    output logic [7:0]        a_dout_o,
    input  logic              b_en_i,
    input  logic [OAM_AW-1:0] b_addr_i,
    output logic [7:0]        b_dout_o
);

    logic [7:0] mem [OAM_DEPTH];
    logic [7:0] aDout_q;
    logic [7:0] bDout_q;

    // Single clocked process with no reset so the array maps onto block RAM.
    // Reads sample the array before this edge's write lands, giving
    // read-first behaviour on both ports.
    always_ff @(posedge clk_i) begin
        if (a_we_i) begin
            mem[a_addr_i] <= a_din_i;
        end
        aDout_q <= mem[a_addr_i];
        if (b_en_i) begin
            bDout_q <= mem[b_addr_i];
        end
    end

    assign a_dout_o = aDout_q;
    assign b_dout_o = bDout_q;

endmodule

// File: rtl/ppu_oam_port.sv
// ppu_oam_port
// PPU-side responder for OAMADDR ($2003, index 3) and OAMDATA ($2004, index 4).
// Owns the 256x8 sprite attribute RAM; CPU and sprite-DMA writes commit on
// ph2_falling, while a separate read port serves sprite evaluation/fetch.
// Ports:
//   clk, rst (async, active low)
//   ph2_falling                     : bus transfer commit strobe
//   slv_mem_select/rnw/addr/din     : PPU slave bus request
//   slv_mem_dout                    : registered OAMDATA read data
//   rendering_active                : PPU is rendering
//   ren_addr_clr                    : zeroes OAMADDR from render timing
//   ren_rd_en, ren_addr, ren_dout   : render read port
//   oam_addr                        : current OAMADDR
module ppu_oam_port
    import ppu_oam_port_pkg::*;
#(
    parameter bit ATTR_MASK_EN = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ph2_falling,
    input  logic       slv_mem_select,
    input  logic       slv_mem_rnw,
    input  logic [2:0] slv_mem_addr,
    input  logic [7:0] slv_mem_din,
    output logic [7:0] slv_mem_dout,
    input  logic       rendering_active,
    input  logic       ren_addr_clr,
    input  logic       ren_rd_en,
    input  logic [7:0] ren_addr,
    output logic [7:0] ren_dout,
    output logic [7:0] oam_addr
);

    logic       wrAddr;
    logic       wrData;
    logic       ramWe;
    logic [7:0] ramWdata;
    logic [7:0] ramDoutA;
    logic [7:0] ramDoutB;
    logic [7:0] oamAddr_q;
    logic [7:0] oamAddr_d;
    logic [7:0] slvDout_q;
    logic       renValid_q;

    assign wrAddr = ph2_falling & slv_mem_select & ~slv_mem_rnw
                  & (slv_mem_addr == PPU_REG_OAMADDR);
    assign wrData = ph2_falling & slv_mem_select & ~slv_mem_rnw
                  & (slv_mem_addr == PPU_REG_OAMDATA);

    // RAM is only written outside rendering, at the pre-increment address.
    assign ramWe    = wrData & ~rendering_active;
    assign ramWdata = oamStoreByte(ATTR_MASK_EN, oamAddr_q, slv_mem_din);

    // OAMADDR next state. During rendering a data write bumps only the
    // sprite index (bits 7:2), leaving the byte-within-sprite untouched.
    always_comb begin
        oamAddr_d = oamAddr_q;
        if (ren_addr_clr) begin
            oamAddr_d = 8'h00;
        end else if (wrAddr) begin
            oamAddr_d = slv_mem_din;
        end else if (wrData && !rendering_active) begin
            oamAddr_d = oamAddr_q + 8'd1;
        end else if (wrData) begin
            oamAddr_d = {oamAddr_q[7:2] + 6'd1, oamAddr_q[1:0]};
        end
    end

    // Address register, bus read-data register and the render-port valid
    // flag. The flag lets ren_dout read 0 straight out of reset without
    // putting a reset on the RAM output register itself.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            oamAddr_q  <= 8'h00;
            slvDout_q  <= 8'h00;
            renValid_q <= 1'b0;
        end else begin
            oamAddr_q <= oamAddr_d;
            slvDout_q <= rendering_active ? ren_dout : ramDoutA;
            if (ren_rd_en) begin
                renValid_q <= 1'b1;
            end
        end
    end

    oam_dpram u_ram (
        .clk_i    (clk),
        .a_we_i   (ramWe),
        .a_addr_i (oamAddr_q),
        .a_din_i  (ramWdata),
        .a_dout_o (ramDoutA),
        .b_en_i   (ren_rd_en),
        .b_addr_i (ren_addr),
        .b_dout_o (ramDoutB)
    );

    assign ren_dout     = renValid_q ? ramDoutB : 8'h00;
    assign slv_mem_dout = slvDout_q;
    assign oam_addr     = oamAddr_q;

endmodule

// File: tb/tb_ppu_oam_port.sv
// tb_ppu_oam_port
// Scoreboard bench for ppu_oam_port. Two instances share all inputs: one
// with attribute masking enabled, one with it disabled. Stimulus pushes
// expected values into a queue; a monitor on the falling clock edge pops
// and compares them against the selected output.
module tb_ppu_oam_port;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ph2Falling = 1'b0;
    logic       sel = 1'b0;
    logic       rnw = 1'b1;
    logic [2:0] regAddr = 3'd0;
    logic [7:0] din = 8'h00;
    logic       rendering = 1'b0;
    logic       addrClr = 1'b0;
    logic       renRdEn = 1'b0;
    logic [7:0] renAddr = 8'h00;

    logic [7:0] slvDoutM, renDoutM, oamAddrM;
    logic [7:0] slvDoutP, renDoutP, oamAddrP;

    int cycle  = 0;
    int errors = 0;
    int checks = 0;

    int         dueQ[$];
    int         selQ[$];
    logic [7:0] expQ[$];
    string      nameQ[$];

    // Output selectors for the scoreboard
    localparam int S_OAM_M = 0;
    localparam int S_SLV_M = 1;
    localparam int S_REN_M = 2;
    localparam int S_OAM_P = 3;
    localparam int S_SLV_P = 4;
    localparam int S_REN_P = 5;

    ppu_oam_port #(.ATTR_MASK_EN(1'b1)) dutMasked (
        .clk              (clk),
        .rst              (rst),
        .ph2_falling      (ph2Falling),
        .slv_mem_select   (sel),
        .slv_mem_rnw      (rnw),
        .slv_mem_addr     (regAddr),
        .slv_mem_din      (din),
        .slv_mem_dout     (slvDoutM),
        .rendering_active (rendering),
        .ren_addr_clr     (addrClr),
        .ren_rd_en        (renRdEn),
        .ren_addr         (renAddr),
        .ren_dout         (renDoutM),
        .oam_addr         (oamAddrM)
    );

    ppu_oam_port #(.ATTR_MASK_EN(1'b0)) dutPlain (
        .clk              (clk),
        .rst              (rst),
        .ph2_falling      (ph2Falling),
        .slv_mem_select   (sel),
        .slv_mem_rnw      (rnw),
        .slv_mem_addr     (regAddr),
        .slv_mem_din      (din),
        .slv_mem_dout     (slvDoutP),
        .rendering_active (rendering),
        .ren_addr_clr     (addrClr),
        .ren_rd_en        (renRdEn),
        .ren_addr         (renAddr),
        .ren_dout         (renDoutP),
        .oam_addr         (oamAddrP)
    );

    // Free-running clock
    always #5 clk = ~clk;

    // Cycle counter used to time scoreboard entries
    always @(posedge clk) cycle <= cycle + 1;

    task automatic pushExp(input int s, input logic [7:0] e, input string n);
        dueQ.push_back(cycle);
        selQ.push_back(s);
        expQ.push_back(e);
        nameQ.push_back(n);
    endtask

    task automatic checkOutput(input int s, input logic [7:0] e, input string n);
        logic [7:0] act;
        case (s)
            S_OAM_M: act = oamAddrM;
            S_SLV_M: act = slvDoutM;
            S_REN_M: act = renDoutM;
            S_OAM_P: act = oamAddrP;
            S_SLV_P: act = slvDoutP;
            default: act = renDoutP;
        endcase
        checks++;
        if (act !== e) begin
            errors++;
            $display("[TB] FAIL %s: got %02h, expected %02h", n, act, e);
        end
    endtask

    // Monitor: on each falling edge, retire every expectation that is due
    initial begin
        forever begin
            @(negedge clk);
            while (dueQ.size() > 0 && dueQ[0] <= cycle) begin
                checkOutput(selQ.pop_front(), expQ.pop_front(), nameQ.pop_front());
                void'(dueQ.pop_front());
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic s, input logic r, input logic [2:0] a,
                                 input logic [7:0] d, input logic strobe);
        sel        = s;
        rnw        = r;
        regAddr    = a;
        din        = d;
        ph2Falling = strobe;
    endtask

    // One bus write followed by idle cycles, giving the 4-clk strobe spacing
    task automatic busWrite(input logic [2:0] a, input logic [7:0] d);
        applyStimulus(1'b1, 1'b0, a, d, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        repeat (3) tick();
    endtask

    task automatic busRead();
        applyStimulus(1'b1, 1'b1, 3'd4, 8'h00, 1'b1);
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        repeat (2) tick();
    endtask

    task automatic renRead(input logic [7:0] a);
        renRdEn = 1'b1;
        renAddr = a;
        tick();
        renRdEn = 1'b0;
    endtask

    initial begin
        bit drained;
        repeat (2) tick();
        rst = 1'b1;
        tick();

        // Seed a byte so the reset check has nonzero values to clear
        busWrite(3'd3, 8'h20);
        busWrite(3'd4, 8'h5A);
        renRead(8'h20);
        pushExp(S_REN_M, 8'h5A, "seed_ren");
        pushExp(S_OAM_M, 8'h21, "seed_oam");
        tick();

        // Reset asserted in the middle of a pending data write
        applyStimulus(1'b1, 1'b0, 3'd4, 8'hC3, 1'b1);
        #1 rst = 1'b0;
        pushExp(S_OAM_M, 8'h00, "rst_oam");
        pushExp(S_SLV_M, 8'h00, "rst_slv");
        pushExp(S_REN_M, 8'h00, "rst_ren");
        pushExp(S_REN_P, 8'h00, "rst_ren_plain");
        tick();
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        tick();
        rst = 1'b1;
        repeat (4) tick();
        pushExp(S_OAM_M, 8'h00, "post_rst_oam");
        renRead(8'h20);
        pushExp(S_REN_M, 8'h5A, "ram_kept");

        // Address wrap across 0xFF
        busWrite(3'd3, 8'hFE);
        busWrite(3'd4, 8'h11);
        busWrite(3'd4, 8'h22);
        busWrite(3'd4, 8'h33);
        pushExp(S_OAM_M, 8'h01, "wrap_oam");
        renRead(8'hFE);
        pushExp(S_REN_M, 8'h01, "wrap_fe_masked");
        pushExp(S_REN_P, 8'h11, "wrap_fe_plain");
        renRead(8'hFF);
        pushExp(S_REN_M, 8'h22, "wrap_ff");
        renRead(8'h00);
        pushExp(S_REN_M, 8'h33, "wrap_00");

        // Attribute masking seen through the OAMDATA read path
        busWrite(3'd3, 8'h02);
        busWrite(3'd4, 8'hFF);
        busWrite(3'd3, 8'h02);
        busRead();
        pushExp(S_SLV_M, 8'hE3, "attr_masked");
        pushExp(S_SLV_P, 8'hFF, "attr_plain");
        pushExp(S_OAM_M, 8'h02, "attr_oam");

        // Full sprite DMA at back-to-back strobe spacing
        busWrite(3'd3, 8'h00);
        for (int i = 0; i < 256; i++) begin
            busWrite(3'd4, 8'(i));
        end
        pushExp(S_OAM_M, 8'h00, "dma_oam");
        pushExp(S_OAM_P, 8'h00, "dma_oam_plain");
        renRead(8'h80);
        pushExp(S_REN_M, 8'h80, "dma_80");
        renRead(8'h06);
        pushExp(S_REN_M, 8'h02, "dma_06");
        pushExp(S_REN_P, 8'h06, "dma_06_plain");
        renRead(8'hFE);
        pushExp(S_REN_M, 8'hE2, "dma_fe");
        renRead(8'hFF);
        pushExp(S_REN_M, 8'hFF, "dma_ff");

        // Writes during rendering skip the RAM and step by a whole sprite
        rendering = 1'b1;
        busWrite(3'd3, 8'h05);
        busWrite(3'd4, 8'hAA);
        pushExp(S_OAM_M, 8'h09, "render_oam");
        renRead(8'h05);
        pushExp(S_REN_M, 8'h05, "render_ram");
        busRead();
        pushExp(S_SLV_M, 8'h05, "render_slv");
        rendering = 1'b0;
        tick();

        // Other register indices are ignored
        busWrite(3'd5, 8'h99);
        pushExp(S_OAM_M, 8'h09, "other_idx");

        // Address clear beats an OAMADDR write in the same cycle
        applyStimulus(1'b1, 1'b0, 3'd3, 8'h40, 1'b1);
        addrClr = 1'b1;
        tick();
        addrClr = 1'b0;
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        tick();
        pushExp(S_OAM_M, 8'h00, "clr_vs_wr");

        // Port-B read colliding with a port-A write at the same address
        busWrite(3'd3, 8'h10);
        applyStimulus(1'b1, 1'b0, 3'd4, 8'h77, 1'b1);
        renRdEn = 1'b1;
        renAddr = 8'h10;
        tick();
        renRdEn = 1'b0;
        applyStimulus(1'b0, 1'b1, 3'd0, 8'h00, 1'b0);
        pushExp(S_REN_M, 8'h10, "collide_old");
        repeat (2) tick();
        renRead(8'h10);
        pushExp(S_REN_M, 8'h77, "collide_new");
        pushExp(S_OAM_M, 8'h11, "collide_oam");

        // Let the monitor retire everything, bounded
        drained = 1'b0;
        for (int k = 0; k < 20; k++) begin
            if (dueQ.size() == 0) begin
                drained = 1'b1;
                break;
            end
            tick();
        end
        if (!drained) begin
            $display("[TB] FAIL scoreboard_drain: got %0d pending, expected 0", dueQ.size());
            checks += dueQ.size();
            errors += dueQ.size();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/ppu_oam_port.md
Name: ppu_oam_port

Overview:
PPU-side responder for the OAM register pair: OAMADDR at index 3 and OAMDATA at index 4. It owns the 256x8 sprite attribute memory. CPU and sprite-DMA writes to OAMDATA arrive over the PPU slave bus, strobed on ph2_falling. A second, independent read port feeds the PPU sprite-evaluation and fetch logic.

Parameters:
ATTR_MASK_EN, 1, when 1, bytes whose address has bits [1:0] = 2 are stored with bits 4:2 forced to 0 (data & 8'hE3).

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
ph2_falling  in  1  single-clk strobe marking the end of the CPU cycle; bus transfers commit here
slv_mem_select  in  1  PPU register window selected
slv_mem_rnw  in  1  1 = read, 0 = write
slv_mem_addr  in  3  PPU register index
slv_mem_din  in  8  CPU/DMA write data
slv_mem_dout  out  8  OAMDATA read data, registered
rendering_active  in  1  PPU is rendering (visible/pre-render line, rendering enabled)
ren_addr_clr  in  1  single-clk pulse from the render timing logic that zeroes OAMADDR
ren_rd_en  in  1  render-port read enable
ren_addr  in  8  render-port byte address
ren_dout  out  8  render-port read data
oam_addr  out  8  current OAMADDR value

Behaviour:
- Reset (rst=0, asynchronous): oam_addr=0, slv_mem_dout=0, ren_dout=0. RAM contents are not cleared.
- Decode:
  - wr_addr = select & ~rnw & addr==3
  - wr_data = select & ~rnw & addr==4
  - rd_data = select & rnw & addr==4
  - The write decodes act only on a clk edge where ph2_falling=1.
- OAMADDR update. Priority, highest first:
  1. ren_addr_clr (any clk) -> 0.
  2. wr_addr -> slv_mem_din.
  3. wr_data with rendering_active=0 -> oam_addr+1, mod 256 (0xFF wraps to 0x00).
  4. wr_data with rendering_active=1 -> oam_addr+4, mod 256; bits [1:0] unchanged.
  5. Otherwise hold.
  - rd_data never changes oam_addr.
- RAM write: only on wr_data with rendering_active=0, to RAM[oam_addr] (the pre-increment address).
  - Stored data = slv_mem_din, masked per ATTR_MASK_EN when oam_addr[1:0]==2.
  - During rendering, wr_data writes nothing to RAM.
- Read ports: one sub-module, a synchronous dual-port RAM.
  - Port A is write/read at oam_addr.
  - Port B is read-only at ren_addr.
  - Read latency is 1 clk. Same-address write and port-B read in the same clk return the old data (read-first).
- slv_mem_dout is updated every clk:
  - rendering_active=0: port-A read of RAM[oam_addr].
  - rendering_active=1: ren_dout.
  - Valid 2 clk after any oam_addr change. The bus guarantees at least 4 clk between ph2_falling strobes, so a read in the CPU cycle after a write sees the new data.
  - Values are already masked at write time, so no read-side masking is applied.
- ren_dout: when ren_rd_en=1, RAM[ren_addr] appears on the next clk. When ren_rd_en=0, ren_dout holds.
- Sprite DMA is an ordinary sequence of 256 wr_data transfers. Starting from oam_addr=N it fills the whole RAM, starting at N with wrap, and leaves oam_addr=N.
- Accesses to other register indices are ignored. No bus error is raised.

Decomposition:
- Shared PPU package:
  - register index constants PPU_REG_OAMADDR=3 and PPU_REG_OAMDATA=4
  - OAM_ATTR_MASK=8'hE3
  - OAM_DEPTH=256
- One sub-module: oam_dpram (256x8, 1 write/read port plus 1 read port, synchronous, read-first, inferable as block RAM).

Test Plan:
- Reset: drive rst low mid-write -> oam_addr, slv_mem_dout and ren_dout all read 0 immediately, without a clk edge; after release, idle bus -> oam_addr stays 0.
- Wrap: write $2003=0xFE, then $2004 writes 0x11, 0x22, 0x33 -> RAM[FE]=11, RAM[FF]=22, RAM[00]=33 (checked via the render port); oam_addr=0x01.
- Attribute mask: $2003=0x02, $2004 write 0xFF, then $2003=0x02 and $2004 read -> slv_mem_dout=0xE3, oam_addr stays 0x02.
  - With ATTR_MASK_EN=0 the same sequence reads 0xFF.
- DMA fill: oam_addr=0, 256 $2004 writes of value i (i = 0..255) -> oam_addr=0x00.
  - Render port ren_addr=0x80 gives 0x80 and ren_addr=0x06 gives 0x02 (0x06 & 0xE3).
  - No write is dropped at back-to-back ph2_falling spacing.
- Rendering: rendering_active=1, oam_addr=0x05, $2004 write 0xAA -> RAM[05] unchanged and oam_addr=0x09; a $2004 read then returns the current ren_dout.
- Collision: ren_addr_clr and a $2003=0x40 write in the same clk -> oam_addr=0x00.
  - Port-B read of RAM[0x10] in the same clk as a $2004 write to 0x10 -> ren_dout shows the old byte, and the new byte on the next read.
